text_console_ctrl: RTL and testbench

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

---
 rtl/text_console_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl.sv
// Text console controller: accepts characters from a CPU-side handshake,
// writes them into a COLS x ROWS word buffer through a shared, granted
// memory port, and handles newline, carriage return, scrolling and
// clear-screen. Every memory access waits for mem_gnt.
module text_console_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        clr_req,
  input  logic        mem_gnt,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        rd_en,
  output logic [11:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PUT, SCROLL_RD, SCROLL_WR, FILL} state_t;

  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_COPY = 12'(COLS * (ROWS - 1) - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [31:0] BLANK     = 32'h20;

  state_t      state, state_nxt;
  logic [6:0]  col, col_nxt;
  logic [4:0]  row, row_nxt;
  logic [11:0] idx, idx_nxt;      // copy index during scroll, fill address in FILL
  logic        pending, pending_nxt;
  logic [7:0]  char_q, char_nxt;
  logic        rd_pend;           // a read was issued last cycle; rd_data is valid now
  logic [31:0] rd_word;
  logic [11:0] cur_addr;

  assign cur_addr = 12'(row) * 12'(COLS) + 12'(col);
  assign cur_col  = col;
  assign cur_row  = row;
  assign busy     = (state != IDLE);
  assign ch_ready = (state == IDLE) && !pending && !rst;

  // State and datapath registers; synchronous reset aborts any operation.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      idx     <= '0;
      pending <= 1'b0;
      char_q  <= '0;
      rd_pend <= 1'b0;
      rd_word <= '0;
    end else begin
      state   <= state_nxt;
      col     <= col_nxt;
      row     <= row_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
      char_q  <= char_nxt;
      rd_pend <= rd_en;
      if (rd_pend) rd_word <= rd_data;
    end
  end

  // Next-state, cursor update and memory port drive.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt   = state;
    col_nxt     = col;
    row_nxt     = row;
    idx_nxt     = idx;
    char_nxt    = char_q;
    pending_nxt = pending | (clr_req && state != IDLE);
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rd_en       = 1'b0;
    rd_addr     = '0;

    case (state)
      IDLE: begin
        if (clr_req || pending) begin
          // Clear wins over a simultaneous character; cursor homes at entry.
          state_nxt   = FILL;
          idx_nxt     = '0;
          col_nxt     = '0;
          row_nxt     = '0;
          pending_nxt = 1'b0;
        end else if (ch_valid) begin
          if (ch_data == 8'h0A) begin
            col_nxt = '0;
            if (row == LAST_ROW) begin
              state_nxt = SCROLL_RD;
              idx_nxt   = '0;
            end else begin
              row_nxt = row + 5'd1;
            end
          end else if (ch_data == 8'h0D) begin
            col_nxt = '0;
          end else begin
            state_nxt = PUT;
            char_nxt  = ch_data;
          end
        end
      end

      PUT: begin
        wr_addr = cur_addr;
        wr_data = {24'h0, char_q};
        if (mem_gnt) begin
          wr_en     = 1'b1;
          state_nxt = IDLE;
          if (col == LAST_COL) begin
            col_nxt = '0;
            if (row == LAST_ROW) begin
              state_nxt = SCROLL_RD;
              idx_nxt   = '0;
            end else begin
              row_nxt = row + 5'd1;
            end
          end else begin
            col_nxt = col + 7'd1;
          end
        end
      end

      SCROLL_RD: begin
        rd_addr = idx + 12'(COLS);
        if (mem_gnt) begin
          rd_en     = 1'b1;
          state_nxt = SCROLL_WR;
        end
      end

      SCROLL_WR: begin
        // Fresh read data is forwarded on the cycle it arrives.
        wr_addr = idx;
        wr_data = rd_pend ? rd_data : rd_word;
        if (mem_gnt) begin
          wr_en     = 1'b1;
          idx_nxt   = idx + 12'd1;
          state_nxt = (idx == LAST_COPY) ? FILL : SCROLL_RD;
        end
      end

      FILL: begin
        wr_addr = idx;
        wr_data = BLANK;
        if (mem_gnt) begin
          wr_en = 1'b1;
          if (idx == LAST_ADDR) state_nxt = IDLE;
          else                  idx_nxt   = idx + 12'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Reset silences the port in the very cycle it is asserted.
    if (rst) begin
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_addr = '0;
      rd_addr = '0;
      wr_data = '0;
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: a local word buffer answers the
// memory port, and expected values are hand-computed per test step.
module tb_text_console_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic        clr_req = 1'b0;
  logic        mem_gnt;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  logic        gnt_lvl = 1'b1;
  logic        gnt_mode = 1'b0;   // 1: grant one cycle in four
  logic [1:0]  gnt_cnt = 2'd0;
  logic        preload = 1'b0;

  logic [31:0] mem [0:2399];
  int          wr_cnt = 0;
  int          viol = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign mem_gnt = gnt_mode ? (gnt_cnt == 2'd0) : gnt_lvl;

  text_console_ctrl #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .clr_req(clr_req), .mem_gnt(mem_gnt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  // Text buffer with one-cycle read latency; preload writes mem[i] = i.
  always @(posedge clk) begin
    gnt_cnt <= gnt_cnt + 2'd1;
    if (preload) begin
      for (int i = 0; i < 2400; i++) mem[i] <= 32'(i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Port-rule monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if ((wr_en || rd_en) && !mem_gnt) viol <= viol + 1;
    if (wr_en && rd_en) viol <= viol + 1;
    if ((wr_en && wr_addr >= 12'd2400) || (rd_en && rd_addr >= 12'd2400)) viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (inputs are driven here).
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one character for one cycle; returns at the sample point of N+1.
  task automatic send(input logic [7:0] c);
    ch_valid = 1'b1;
    ch_data  = c;
    step();
    ch_valid = 1'b0;
    #1;
  endtask

  // Wait (bounded) until busy drops; n counts busy cycles seen.
  task automatic wait_idle(input string tag, input int limit, output int n);
    n = 0;
    while (busy) begin
      if (n >= limit) begin
        check({tag, "_timeout"}, 32'(n), 32'(limit + 1));
        return;
      end
      n++;
      step();
      #1;
    end
  endtask

  task automatic put_n(input logic [7:0] c, input int count);
    int n;
    for (int i = 0; i < count; i++) begin
      send(c);
      wait_idle("put", 100, n);
    end
  endtask

  task automatic load_mem();
    preload = 1'b1;
    step();
    preload = 1'b0;
    #1;
  endtask

  function automatic int scroll_diffs();
    int d = 0;
    logic [31:0] e;
    for (int i = 0; i < 2400; i++) begin
      if (i < 2319)       e = 32'(i + 80);
      else if (i == 2319) e = 32'h43;
      else                e = 32'h20;
      if (mem[i] !== e) d++;
    end
    return d;
  endfunction

  initial begin
    int n, w0, cnt;
    int first_rd, first_wr, last_rd, last_cp;
    logic [31:0] first_wr_data, last_cp_data;
    bit seen_rd, seen_wr;

    // Reset values while rst is held, then readiness right after release.
    step(); step(); #1;
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cursor", {cur_row, cur_col}, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", ch_ready, 1);

    // 'A' at 0,0: write one cycle after accept, ready the cycle after.
    send(8'h41);
    check("a_wr_en", wr_en, 1);
    check("a_wr_addr", wr_addr, 0);
    check("a_wr_data", wr_data, 32'h41);
    step(); #1;
    check("a_ready", ch_ready, 1);
    check("a_col", cur_col, 1);
    check("a_row", cur_row, 0);

    // End-of-row wrap, then newline without a write.
    put_n(8'h78, 78);
    check("col79", cur_col, 79);
    send(8'h42);
    check("b_wr_addr", wr_addr, 79);
    check("b_wr_data", wr_data, 32'h42);
    wait_idle("b", 10, n);
    check("b_cursor", {cur_row, cur_col}, {5'd1, 7'd0});
    w0 = wr_cnt;
    send(8'h0A);
    check("lf_busy", busy, 0);
    check("lf_wr_en", wr_en, 0);
    check("lf_cursor", {cur_row, cur_col}, {5'd2, 7'd0});
    step(); step(); #1;
    check("lf_no_write", 32'(wr_cnt - w0), 0);

    // Carriage return after a character at row 2.
    send(8'h43);
    check("c_wr_addr", wr_addr, 160);
    wait_idle("c", 10, n);
    send(8'h0D);
    check("cr_cursor", {cur_row, cur_col}, {5'd2, 7'd0});
    check("cr_wr_en", wr_en, 0);

    // Grant withheld: PUT holds address with enables low.
    gnt_lvl = 1'b0;
    send(8'h44);
    check("hold_wr_en", wr_en, 0);
    check("hold_busy", busy, 1);
    check("hold_addr", wr_addr, 160);
    step(); #1;
    check("hold_wr_en2", wr_en, 0);
    check("hold_addr2", wr_addr, 160);
    gnt_lvl = 1'b1;
    #1;
    check("hold_release_wr", wr_en, 1);
    check("hold_release_data", wr_data, 32'h44);
    step(); #1;
    check("hold_ready", ch_ready, 1);
    check("hold_col", cur_col, 1);

    // Clear beats a simultaneous character.
    clr_req  = 1'b1;
    ch_valid = 1'b1;
    ch_data  = 8'h45;
    step();
    clr_req  = 1'b0;
    ch_valid = 1'b0;
    #1;
    w0 = wr_cnt;
    check("clr_busy", busy, 1);
    check("clr_first_addr", wr_addr, 0);
    check("clr_first_data", wr_data, 32'h20);
    check("clr_cursor", {cur_row, cur_col}, 0);
    wait_idle("clr", 3000, n);
    check("clr_writes", 32'(wr_cnt - w0), 2400);
    check("clr_mem0", mem[0], 32'h20);
    check("clr_mem160", mem[160], 32'h20);
    check("clr_mem2399", mem[2399], 32'h20);

    // Continuous-grant scroll from 29,79.
    put_n(8'h0A, 29);
    put_n(8'h7A, 79);
    check("pre_scroll_cursor", {cur_row, cur_col}, {5'd29, 7'd79});
    load_mem();
    send(8'h43);
    check("scr_put_addr", wr_addr, 2399);
    check("scr_put_data", wr_data, 32'h43);
    seen_rd = 0; seen_wr = 0; cnt = 0;
    first_rd = 0; first_wr = 0; last_rd = 0; last_cp = 0;
    first_wr_data = 0; last_cp_data = 0;
    for (int k = 0; k < 6000; k++) begin
      step(); #1;
      if (!busy) break;
      cnt++;
      if (rd_en && !seen_rd) begin first_rd = rd_addr; seen_rd = 1; end
      if (wr_en && !seen_wr) begin first_wr = wr_addr; first_wr_data = wr_data; seen_wr = 1; end
      if (rd_en) last_rd = rd_addr;
      if (wr_en && wr_data != 32'h20) begin last_cp = wr_addr; last_cp_data = wr_data; end
    end
    check("scr_busy_cycles", 32'(cnt), 4720);
    check("scr_first_rd", 32'(first_rd), 80);
    check("scr_first_wr", 32'(first_wr), 0);
    check("scr_first_data", first_wr_data, 80);
    check("scr_last_rd", 32'(last_rd), 2399);
    check("scr_last_cp", 32'(last_cp), 2319);
    check("scr_last_cp_data", last_cp_data, 32'h43);
    check("scr_cursor", {cur_row, cur_col}, {5'd29, 7'd0});
    check("scr_buf_diffs", 32'(scroll_diffs()), 0);

    // Same scroll with one grant every four cycles.
    put_n(8'h7A, 79);
    load_mem();
    gnt_mode = 1'b1;
    send(8'h43);
    wait_idle("gscr", 30000, n);
    gnt_mode = 1'b0;
    check("gscr_buf_diffs", 32'(scroll_diffs()), 0);
    check("gscr_cursor", {cur_row, cur_col}, {5'd29, 7'd0});

    // Two clear requests during a scroll collapse into one clear afterwards.
    put_n(8'h7A, 79);
    send(8'h43);
    repeat (100) step();
    clr_req = 1'b1; step(); clr_req = 1'b0;
    repeat (50) step();
    clr_req = 1'b1; step(); clr_req = 1'b0;
    #1;
    wait_idle("pscr", 6000, n);
    check("pend_not_ready", ch_ready, 0);
    step(); #1;
    check("pend_clr_busy", busy, 1);
    check("pend_clr_cursor", {cur_row, cur_col}, 0);
    check("pend_clr_data", wr_data, 32'h20);
    w0 = wr_cnt;
    wait_idle("pclr", 3000, n);
    check("pend_clr_writes", 32'(wr_cnt - w0), 2400);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      if (busy) cnt++;
    end
    check("pend_single_clear", 32'(cnt), 0);
    check("pend_ready", ch_ready, 1);

    // Reset in the middle of a clear, just before address 1000 is written.
    load_mem();
    clr_req = 1'b1; step(); clr_req = 1'b0; #1;
    cnt = 0;
    while (!(wr_en && wr_addr == 12'd1000) && cnt < 3000) begin
      step(); #1; cnt++;
    end
    check("fill_reach_1000", 32'(wr_addr), 1000);
    rst = 1'b1;
    step(); #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_wr_en", wr_en, 0);
    check("rstmid_cursor", {cur_row, cur_col}, 0);
    rst = 1'b0;
    #1;
    check("rstmid_ready", ch_ready, 1);
    step(); step(); #1;
    check("rstmid_mem999", mem[999], 32'h20);
    check("rstmid_mem1000", mem[1000], 32'd1000);
    check("rstmid_mem2399", mem[2399], 32'd2399);

    check("port_rule_violations", 32'(viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
